// File: rtl/gradation_display_if.sv
// Video output bundle for the gradation test-pattern generator: RGB888,
// syncs, data enable and the derived pixel clock.
interface gradation_display_if;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_DE;
    logic       PCK;

    modport master (
        output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE, PCK
    );

    modport slave (
        input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE, PCK
    );
endinterface

// File: rtl/gradation_display.sv
// VGA-timed test image: four horizontal colour bands, each a 0..255 ramp
// across the line, paced by a divide-by-CLKDIV pixel tick on the system clock.
module gradation_display #(
    parameter int unsigned CLKDIV   = 5,
    parameter int unsigned HVISIBLE = 640,
    parameter int unsigned HFRONT   = 16,
    parameter int unsigned HSYNC    = 96,
    parameter int unsigned HBACK    = 48,
    parameter int unsigned VVISIBLE = 480,
    parameter int unsigned VFRONT   = 10,
    parameter int unsigned VSYNC    = 2,
    parameter int unsigned VBACK    = 33
) (
    input  logic                 CLK,
    input  logic                 RST,
    gradation_display_if.master  vid
);
    localparam int unsigned HTOTAL = HVISIBLE + HFRONT + HSYNC + HBACK;
    localparam int unsigned VTOTAL = VVISIBLE + VFRONT + VSYNC + VBACK;
    localparam int unsigned DIV_W  = $clog2(CLKDIV);
    localparam int unsigned HC_W   = $clog2(HTOTAL);
    localparam int unsigned VC_W   = $clog2(VTOTAL);
    localparam int unsigned LVL_W  = HC_W + 1;
    localparam int unsigned BAND   = VVISIBLE / 4;

    logic [DIV_W-1:0] div;
    logic [HC_W-1:0]  hc;
    logic [VC_W-1:0]  vc;

    logic             tick_c;
    logic             h_last_c;
    logic             v_last_c;
    logic             de_c;
    logic             hs_c;
    logic             vs_c;
    logic [LVL_W-1:0] dbl_c;
    logic [7:0]       lvl_c;
    logic [7:0]       r_c;
    logic [7:0]       g_c;
    logic [7:0]       b_c;

    // Pixel decode from the current raster position.
    always_comb begin
        tick_c   = (div == DIV_W'(CLKDIV - 1));
        h_last_c = (hc == HC_W'(HTOTAL - 1));
        v_last_c = (vc == VC_W'(VTOTAL - 1));
        de_c     = (hc < HC_W'(HVISIBLE)) && (vc < VC_W'(VVISIBLE));
        hs_c     = !((hc >= HC_W'(HVISIBLE + HFRONT)) &&
                     (hc <  HC_W'(HVISIBLE + HFRONT + HSYNC)));
        vs_c     = !((vc >= VC_W'(VVISIBLE + VFRONT)) &&
                     (vc <  VC_W'(VVISIBLE + VFRONT + VSYNC)));
        // Exact floor(2*hc/5); only meaningful (and <= 255) on visible pixels.
        dbl_c    = {hc, 1'b0};
        lvl_c    = 8'(dbl_c / LVL_W'(5));
        r_c      = '0;
        g_c      = '0;
        b_c      = '0;
        if (de_c) begin
            if (vc < VC_W'(BAND)) begin
                r_c = lvl_c;
            end else if (vc < VC_W'(2 * BAND)) begin
                g_c = lvl_c;
            end else if (vc < VC_W'(3 * BAND)) begin
                b_c = lvl_c;
            end else begin
                r_c = lvl_c;
                g_c = lvl_c;
                b_c = lvl_c;
            end
        end
    end

    // Divider, raster counters and registered video outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            div        <= '0;
            hc         <= '0;
            vc         <= '0;
            vid.PCK    <= 1'b0;
            vid.VGA_HS <= 1'b1;
            vid.VGA_VS <= 1'b1;
            vid.VGA_DE <= 1'b0;
            vid.VGA_R  <= '0;
            vid.VGA_G  <= '0;
            vid.VGA_B  <= '0;
        end else begin
            div <= tick_c ? '0 : div + DIV_W'(1);
            // Registered one step early so PCK is high exactly while div is 2..3.
            vid.PCK <= (div == DIV_W'(1)) || (div == DIV_W'(2));
            if (tick_c) begin
                vid.VGA_HS <= hs_c;
                vid.VGA_VS <= vs_c;
                vid.VGA_DE <= de_c;
                vid.VGA_R  <= r_c;
                vid.VGA_G  <= g_c;
                vid.VGA_B  <= b_c;
                hc <= h_last_c ? '0 : hc + HC_W'(1);
                if (h_last_c) begin
                    vc <= v_last_c ? '0 : vc + VC_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_gradation_display.sv
// Directed bench for gradation_display: reset, PCK waveform, line/frame
// timing, band pixels, frame wrap and mid-frame reset (short vertical frame).
module tb_gradation_display;
    localparam int unsigned VVIS = 8;
    localparam int unsigned VFR  = 1;
    localparam int unsigned VSY  = 2;
    localparam int unsigned VBK  = 1;
    localparam int unsigned VTOT = VVIS + VFR + VSY + VBK;
    localparam int unsigned HTOT = 800;
    localparam int unsigned NDIR = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pck_prev = 1'b0;
    logic pck_now = 1'b0;
    logic timed_out = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Directed pixels {DE,R,G,B}; bands are two lines tall in this frame.
    int          dx   [NDIR] = '{0, 5, 639, 640, 100, 320, 2, 3, 639, 639};
    int          dy   [NDIR] = '{0, 0, 0,   0,   2,   4,   6, 6, 7,   8};
    logic [24:0] dexp [NDIR] = '{25'h1_000000, 25'h1_020000, 25'h1_FF0000, 25'h0_000000,
                                 25'h1_002800, 25'h1_000080, 25'h1_000000, 25'h1_010101,
                                 25'h1_FFFFFF, 25'h0_000000};

    always #4 clk = ~clk;

    gradation_display_if vid ();

    gradation_display #(
        .VVISIBLE (VVIS),
        .VFRONT   (VFR),
        .VSYNC    (VSY),
        .VBACK    (VBK)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .vid (vid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        pck_prev = pck_now;
        pck_now  = vid.PCK;
    endtask

    // Advance to the next PCK rising edge, bounded.
    task automatic next_pck();
        if (timed_out) return;
        for (int i = 0; i < 10; i++) begin
            step();
            if (pck_now && !pck_prev) return;
        end
        timed_out = 1'b1;
    endtask

    function automatic logic [24:0] obs();
        return {vid.VGA_DE, vid.VGA_R, vid.VGA_G, vid.VGA_B};
    endfunction

    function automatic logic [24:0] model(input int x, input int y);
        logic [7:0] l;
        l = 8'((2 * x) / 5);
        if (x >= 640 || y >= int'(VVIS)) return 25'h0;
        case (y / int'(VVIS / 4))
            0:       return {1'b1, l, 8'h00, 8'h00};
            1:       return {1'b1, 8'h00, l, 8'h00};
            2:       return {1'b1, 8'h00, 8'h00, l};
            default: return {1'b1, l, l, l};
        endcase
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_pck"}, 32'(vid.PCK), 32'd0);
        check({tag, "_hs"},  32'(vid.VGA_HS), 32'd1);
        check({tag, "_vs"},  32'(vid.VGA_VS), 32'd1);
        check({tag, "_de"},  32'(vid.VGA_DE), 32'd0);
        check({tag, "_rgb"}, 32'({vid.VGA_R, vid.VGA_G, vid.VGA_B}), 32'd0);
    endtask

    initial begin
        logic [9:0]  pck_pat;
        logic [9:0]  de_pat;
        logic [24:0] o;
        int line_de, line_hs, line_vs, hs_first, hs_last;
        int de_lines, de_pix, bad_lines, vs_lines, vs_first, vs_partial, hs_total, bad;

        de_lines = 0; de_pix = 0; bad_lines = 0; vs_lines = 0; vs_first = -1;
        vs_partial = 0; hs_total = 0; bad = 0; pck_pat = '0; de_pat = '0;

        rst = 1'b1;
        repeat (20) step();
        check_reset_values("reset");

        // PCK period 5, high for 2; first tick on the fifth CLK after release.
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            pck_pat[k] = vid.PCK;
            de_pat[k]  = vid.VGA_DE;
        end
        check("pck_wave",   32'(pck_pat), 32'd198);
        check("first_tick", 32'(de_pat),  32'd1008);

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        next_pck();
        check("pre_tick_de", 32'(vid.VGA_DE), 32'd0);

        for (int y = 0; y < int'(VTOT); y++) begin
            line_de = 0; line_hs = 0; line_vs = 0; hs_first = -1; hs_last = -1;
            for (int x = 0; x < int'(HTOT); x++) begin
                next_pck();
                o = obs();
                if (o[24]) line_de++;
                if (!vid.VGA_HS) begin
                    line_hs++;
                    if (hs_first < 0) hs_first = x;
                    hs_last = x;
                end
                if (!vid.VGA_VS) line_vs++;
                if (o !== model(x, y)) bad++;
                for (int d = 0; d < int'(NDIR); d++) begin
                    if (dx[d] == x && dy[d] == y)
                        check($sformatf("pix_%0d_%0d", x, y), 32'(o), 32'(dexp[d]));
                end
            end
            if (y == 0) begin
                check("line0_de",       32'(line_de),  32'd640);
                check("line0_hs_count", 32'(line_hs),  32'd96);
                check("line0_hs_first", 32'(hs_first), 32'd656);
                check("line0_hs_last",  32'(hs_last),  32'd751);
            end
            if (line_de > 0) de_lines++;
            if (line_de != ((y < int'(VVIS)) ? 640 : 0)) bad_lines++;
            de_pix   += line_de;
            hs_total += line_hs;
            if (line_vs == int'(HTOT)) begin
                vs_lines++;
                if (vs_first < 0) vs_first = y;
            end else if (line_vs != 0) begin
                vs_partial++;
            end
        end
        check("de_lines",   32'(de_lines),   32'(VVIS));
        check("de_bad_lines", 32'(bad_lines), 32'd0);
        check("de_pixels",  32'(de_pix),     32'(VVIS * 640));
        check("vs_lines",   32'(vs_lines),   32'd2);
        check("vs_first",   32'(vs_first),   32'(VVIS + VFR));
        check("vs_partial", 32'(vs_partial), 32'd0);
        check("hs_total",   32'(hs_total),   32'(96 * VTOT));
        check("image",      32'(bad),        32'd0);

        next_pck();
        check("wrap_pixel", 32'(obs()), 32'h1_000000);
        check("wrap_vs",    32'(vid.VGA_VS), 32'd1);

        // Into frame 2 up to pixel (5,2), then reset mid-frame.
        repeat (2 * HTOT + 5) next_pck();
        check("pre_reset_pixel", 32'(obs()), 32'h1_000200);
        rst = 1'b1;
        step();
        check_reset_values("midrst");
        repeat (2) step();
        rst = 1'b0;
        next_pck();
        check("midrst_pre_tick_de", 32'(vid.VGA_DE), 32'd0);
        next_pck();
        check("restart_pixel", 32'(obs()), 32'h1_000000);
        repeat (5) next_pck();
        check("restart_x5", 32'(obs()), 32'h1_020000);

        check("pck_timeout", 32'(timed_out), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
